// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier for the MUL* codes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  ALU_selection,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   localparam logic [4:0] c_ALU_MUL    = 5'd16;
   localparam logic [4:0] c_ALU_MULH   = 5'd17;
   localparam logic [4:0] c_ALU_MULHSU = 5'd18;
   localparam logic [4:0] c_ALU_MULHU  = 5'd19;
   localparam logic [4:0] c_ALU_DIV    = 5'd20;
   localparam logic [4:0] c_ALU_DIVU   = 5'd21;
   localparam logic [4:0] c_ALU_REM    = 5'd22;
   localparam logic [4:0] c_ALU_REMU   = 5'd23;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [4:0]  r_op;
   logic        r_neg;
   logic        r_rem_neg;
   logic [4:0]  r_count;
   logic [63:0] r_mcand;
   logic [31:0] r_mplier;
   logic [63:0] r_acc;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvsr;

   logic        w_is_mul;
   logic        w_is_div;
   logic        w_a_signed;
   logic        w_b_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_div_zero;
   logic        w_div_ovf;
   logic [31:0] w_special_res;

   logic [63:0] w_acc_nxt;
   logic [63:0] w_prod;
   logic [32:0] w_rem_sh;
   logic [32:0] w_sub;
   logic        w_q_bit;
   logic [31:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;
   logic [31:0] w_quo_fin;
   logic [31:0] w_rem_fin;
   logic [31:0] w_calc_res;

   logic        w_accept;
   logic        w_load;
   logic [31:0] w_res_val;

   // Operation decode and operand conditioning on the live inputs
   assign w_is_mul   = (ALU_selection >= c_ALU_MUL) && (ALU_selection <= c_ALU_MULHU);
   assign w_is_div   = (ALU_selection >= c_ALU_DIV) && (ALU_selection <= c_ALU_REMU);
   assign w_a_signed = (ALU_selection == c_ALU_MULH) || (ALU_selection == c_ALU_MULHSU) ||
                       (ALU_selection == c_ALU_DIV)  || (ALU_selection == c_ALU_REM);
   assign w_b_signed = (ALU_selection == c_ALU_MULH) || (ALU_selection == c_ALU_DIV) ||
                       (ALU_selection == c_ALU_REM);
   assign w_a_neg    = w_a_signed & a[31];
   assign w_b_neg    = w_b_signed & b[31];
   assign w_a_mag    = w_a_neg ? (~a + 32'd1) : a;
   assign w_b_mag    = w_b_neg ? (~b + 32'd1) : b;
   assign w_div_zero = w_is_div && (b == 32'd0);
   assign w_div_ovf  = ((ALU_selection == c_ALU_DIV) || (ALU_selection == c_ALU_REM)) &&
                       (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   always_comb begin
      w_special_res = 32'd0;
      if (w_div_zero) begin
         if ((ALU_selection == c_ALU_DIV) || (ALU_selection == c_ALU_DIVU))
            w_special_res = 32'hFFFF_FFFF;
         else
            w_special_res = a;
      end else if (ALU_selection == c_ALU_DIV) begin
         w_special_res = 32'h8000_0000;
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   logic signed [32:0] w_a_ext;
   logic signed [32:0] w_b_ext;
   logic signed [65:0] w_fast_full;
   logic [31:0]        w_fast_res;

   assign w_a_ext     = {w_a_signed & a[31], a};
   assign w_b_ext     = {w_b_signed & b[31], b};
   assign w_fast_full = w_a_ext * w_b_ext;
   assign w_fast_res  = (ALU_selection == c_ALU_MUL) ? w_fast_full[31:0] : w_fast_full[63:32];
`endif

   // One iteration of each engine; the last iteration feeds the result mux directly
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_prod    = r_neg ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
   assign w_rem_sh  = {r_rem, r_quo[31]};
   assign w_sub     = w_rem_sh - {1'b0, r_dvsr};
   assign w_q_bit   = ~w_sub[32];
   assign w_rem_nxt = w_q_bit ? w_sub[31:0] : w_rem_sh[31:0];
   assign w_quo_nxt = {r_quo[30:0], w_q_bit};
   assign w_quo_fin = r_neg ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
   assign w_rem_fin = r_rem_neg ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

   always_comb begin
      w_calc_res = 32'd0;
      case (r_op)
         c_ALU_MUL:                          w_calc_res = w_prod[31:0];
         c_ALU_MULH, c_ALU_MULHSU,
         c_ALU_MULHU:                        w_calc_res = w_prod[63:32];
         c_ALU_DIV, c_ALU_DIVU:              w_calc_res = w_quo_fin;
         c_ALU_REM, c_ALU_REMU:              w_calc_res = w_rem_fin;
         default:                            w_calc_res = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Flush overrides both a new start and a completing calculation
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_load    = 1'b0;
      w_res_val = 32'd0;
      if (flush) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && (w_is_mul || w_is_div)) begin
                  w_accept = 1'b1;
                  if (w_div_zero || w_div_ovf) begin
                     w_next    = S_DONE;
                     w_load    = 1'b1;
                     w_res_val = w_special_res;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (w_is_mul) begin
                     w_next    = S_DONE;
                     w_load    = 1'b1;
                     w_res_val = w_fast_res;
                  end
`endif
                  else begin
                     w_next = S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (r_count == 5'd31) begin
                  w_next    = S_DONE;
                  w_load    = 1'b1;
                  w_res_val = w_calc_res;
               end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op      <= 5'd0;
         r_neg     <= 1'b0;
         r_rem_neg <= 1'b0;
         r_count   <= 5'd0;
         r_mcand   <= 64'd0;
         r_mplier  <= 32'd0;
         r_acc     <= 64'd0;
         r_rem     <= 32'd0;
         r_quo     <= 32'd0;
         r_dvsr    <= 32'd0;
         result    <= 32'd0;
      end else begin
         if (w_accept) begin
            r_op      <= ALU_selection;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_count   <= 5'd0;
            r_mcand   <= {32'd0, w_a_mag};
            r_mplier  <= w_b_mag;
            r_acc     <= 64'd0;
            r_rem     <= 32'd0;
            r_quo     <= w_a_mag;
            r_dvsr    <= w_b_mag;
         end else if (r_state == S_CALC) begin
            r_count   <= r_count + 5'd1;
            r_mcand   <= {r_mcand[62:0], 1'b0};
            r_mplier  <= {1'b0, r_mplier[31:1]};
            r_acc     <= w_acc_nxt;
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
         end
         if (w_load)
            result <= w_res_val;
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);

endmodule

`default_nettype wire
